// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus: hazard sources from the pipeline and the stall/flush
// controls returned to it.
//   master : pipeline side, drives hazard sources, receives controls
//   slave  : sequencer side, receives hazard sources, drives controls
interface hazard_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       idRs;
    logic [4:0]       idRt;
    logic             idUsesRt;
    logic             exMemRead;
    logic [4:0]       exRt;
    logic             mdStart;
    logic             pcSrc;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             idExWrite;
    logic             idExBubble;
    logic             exMemBubble;
    logic             ifIdFlush;
    logic             idExFlush;
    logic             exMemFlush;
    logic             mdBusy;
    logic             mdDone;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output idRs, idRt, idUsesRt, exMemRead, exRt, mdStart, pcSrc,
        input  pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble,
               ifIdFlush, idExFlush, exMemFlush, mdBusy, mdDone, stallCycles
    );

    modport slave (
        input  idRs, idRt, idUsesRt, exMemRead, exRt, mdStart, pcSrc,
        output pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble,
               ifIdFlush, idExFlush, exMemFlush, mdBusy, mdDone, stallCycles
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer for the 5-stage MIPS CPU: load-use stalls,
// multi-cycle mult/div occupancy of EX, and taken-branch flushes.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : hazard sources in; PC/IF-ID/ID-EX enables, bubbles, flushes,
//                mult/div status and the stall-cycle counter out
// Controls are combinational from state and inputs; stallCycles is registered.
module hazard_sequencer #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_sequencer_if.slave bus
);
    localparam int unsigned   MD_CNT_W  = $clog2(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0]    STALL_MAX = '1;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic load_use_c;
    logic pc_write_c, if_id_write_c, id_ex_write_c;
    logic id_ex_bubble_c, ex_mem_bubble_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;
    logic md_busy_c, md_done_c;

    // Load in EX whose destination feeds a source of the instruction in ID.
    assign load_use_c = bus.exMemRead && (bus.exRt != 5'd0) &&
                        ((bus.exRt == bus.idRs) ||
                         (bus.idUsesRt && (bus.exRt == bus.idRt)));

    // State register and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next state and control decode; priority pcSrc > mult/div > load-use.
    always_comb begin
        state_d         = state_q;
        md_cnt_d        = md_cnt_q;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        id_ex_write_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_flush_c  = 1'b0;
        md_busy_c       = 1'b0;
        md_done_c       = 1'b0;

        if (rst_n) begin
            md_busy_c = (state_q == MD_BUSY);
            if (bus.pcSrc) begin
                // Anything in flight behind the branch, mult/div included, is squashed.
                if_id_flush_c  = 1'b1;
                id_ex_flush_c  = 1'b1;
                ex_mem_flush_c = 1'b1;
                state_d        = RUN;
                md_cnt_d       = '0;
            end else if (state_q == MD_BUSY) begin
                if (md_cnt_q != '0) begin
                    pc_write_c      = 1'b0;
                    if_id_write_c   = 1'b0;
                    id_ex_write_c   = 1'b0;
                    ex_mem_bubble_c = 1'b1;
                    md_cnt_d        = md_cnt_q - MD_CNT_W'(1);
                end else begin
                    // ID/EX still holds the finishing mult/div, so mdStart is stale here.
                    md_done_c = 1'b1;
                    state_d   = RUN;
                end
            end else if (bus.mdStart) begin
                pc_write_c      = 1'b0;
                if_id_write_c   = 1'b0;
                id_ex_write_c   = 1'b0;
                ex_mem_bubble_c = 1'b1;
                md_cnt_d        = MD_LOAD;
                state_d         = MD_BUSY;
            end else if (load_use_c) begin
                // The bubble clears exMemRead, so each load stalls exactly once.
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
            end
        end

        stall_cycles_d = (!pc_write_c && (stall_cycles_q != STALL_MAX))
                       ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    end

    assign bus.pcWrite     = pc_write_c;
    assign bus.ifIdWrite   = if_id_write_c;
    assign bus.idExWrite   = id_ex_write_c;
    assign bus.idExBubble  = id_ex_bubble_c;
    assign bus.exMemBubble = ex_mem_bubble_c;
    assign bus.ifIdFlush   = if_id_flush_c;
    assign bus.idExFlush   = id_ex_flush_c;
    assign bus.exMemFlush  = ex_mem_flush_c;
    assign bus.mdBusy      = md_busy_c;
    assign bus.mdDone      = md_done_c;
    assign bus.stallCycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: table of per-cycle stimulus with hand-derived
// expected controls and stall count, checked through a scoreboard queue, plus
// reset checks. A second instance with a 2-bit counter shares the stimulus to
// exercise counter saturation.
module tb_hazard_sequencer;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SAT_W = 2;
    localparam int unsigned SAT_MAX = 3;

    // Flag order: pcWrite ifIdWrite idExWrite idExBubble exMemBubble
    //             ifIdFlush idExFlush exMemFlush mdBusy mdDone
    localparam logic [9:0] E_IDLE = 10'b111_00_000_00;
    localparam logic [9:0] E_LU   = 10'b001_10_000_00;
    localparam logic [9:0] E_MDE  = 10'b000_01_000_00;
    localparam logic [9:0] E_MDB  = 10'b000_01_000_10;
    localparam logic [9:0] E_MDD  = 10'b111_00_000_11;
    localparam logic [9:0] E_FL   = 10'b111_00_111_00;
    localparam logic [9:0] E_FLB  = 10'b111_00_111_10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();
    hazard_sequencer_if #(.CNT_W(SAT_W)) bus_s ();

    hazard_sequencer #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    hazard_sequencer #(.MD_LATENCY(4), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        mem_read;
        logic [4:0]  ex_rt;
        logic        md_start;
        logic        pc_src;
        logic [9:0]  exp_flags;
        int unsigned exp_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [9:0]  flags;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int rs, input int rt, input int uses, input int mr,
                                input int ex_rt, input int md, input int pc,
                                input logic [9:0] f, input int unsigned c);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = 1'(uses); v.mem_read = 1'(mr);
        v.ex_rt = 5'(ex_rt); v.md_start = 1'(md); v.pc_src = 1'(pc);
        v.exp_flags = f; v.exp_cnt = c;
        return v;
    endfunction

    function automatic logic [9:0] cur_flags();
        return {bus.pcWrite, bus.ifIdWrite, bus.idExWrite, bus.idExBubble, bus.exMemBubble,
                bus.ifIdFlush, bus.idExFlush, bus.exMemFlush, bus.mdBusy, bus.mdDone};
    endfunction

    task automatic drive(input vec_t v);
        bus.idRs = v.rs;       bus_s.idRs = v.rs;
        bus.idRt = v.rt;       bus_s.idRt = v.rt;
        bus.idUsesRt = v.uses_rt;   bus_s.idUsesRt = v.uses_rt;
        bus.exMemRead = v.mem_read; bus_s.exMemRead = v.mem_read;
        bus.exRt = v.ex_rt;    bus_s.exRt = v.ex_rt;
        bus.mdStart = v.md_start;   bus_s.mdStart = v.md_start;
        bus.pcSrc = v.pc_src;  bus_s.pcSrc = v.pc_src;
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        drive(v);
        e.name  = name;
        e.flags = v.exp_flags;
        e.cnt   = v.exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check_flags(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: flags got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: outputs settle mid-cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e_cur = sb.pop_front();
            check_flags(e_cur.name, cur_flags(), e_cur.flags);
            check_val({e_cur.name, " stallCycles"}, longint'(bus.stallCycles), longint'(e_cur.cnt));
            check_val({e_cur.name, " sat stallCycles"}, longint'(bus_s.stallCycles),
                      longint'((e_cur.cnt > SAT_MAX) ? SAT_MAX : e_cur.cnt));
        end
    end

    vec_t tbl[24];
    vec_t tail[5];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 0);
        tbl[1]  = mk(5, 0, 0, 1, 5, 0, 0, E_LU,   0);   // load-use on rs
        tbl[2]  = mk(5, 0, 0, 0, 5, 0, 0, E_IDLE, 1);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, E_IDLE, 1);   // exRt = $zero never stalls
        tbl[4]  = mk(3, 5, 0, 1, 5, 0, 0, E_IDLE, 1);   // rt match but rt unused
        tbl[5]  = mk(3, 5, 1, 1, 5, 0, 0, E_LU,   1);   // rt match, rt used
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 2);
        tbl[7]  = mk(5, 0, 0, 1, 5, 0, 1, E_FL,   2);   // flush beats load-use
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, E_MDE,  2);   // mult/div held high: T
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, E_MDB,  3);   // T+1
        tbl[11] = mk(5, 0, 0, 1, 5, 1, 0, E_MDB,  4);   // T+2, load-use ignored
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, E_MDD,  5);   // T+3 done
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 5);   // T+4 back in RUN
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, E_MDE,  5);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 1, E_FLB,  6);   // branch squashes mult/div
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 6);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 1, E_FL,   6);   // mdStart ignored under flush
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 6);
        tbl[19] = mk(5, 0, 0, 1, 5, 1, 0, E_MDE,  6);   // mult/div beats load-use
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, E_MDB,  7);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, E_MDB,  8);
        tbl[22] = mk(0, 0, 0, 0, 0, 1, 0, E_MDD,  9);   // mdStart ignored on done
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 9);

        tail[0] = mk(0, 0, 0, 0, 0, 1, 0, E_MDE,  0);
        tail[1] = mk(0, 0, 0, 0, 0, 1, 0, E_MDB,  1);
        tail[2] = mk(0, 0, 0, 0, 0, 0, 0, E_MDB,  2);
        tail[3] = mk(0, 0, 0, 0, 0, 0, 0, E_MDD,  3);
        tail[4] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE, 3);

        // In reset every hazard source is active, yet controls stay at defaults.
        drive(mk(5, 0, 0, 1, 5, 1, 1, E_IDLE, 0));
        #1;
        check_flags("reset flags", cur_flags(), E_IDLE);
        check_val("reset stallCycles", longint'(bus.stallCycles), 0);
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset flags held", cur_flags(), E_IDLE);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // Reset while a mult/div is occupying EX.
        apply(mk(0, 0, 0, 0, 0, 1, 0, E_MDE, 9), "pre-reset md entry");
        @(posedge clk);
        #1;
        check_val("mdBusy before reset", longint'(bus.mdBusy), 1);
        rst_n = 1'b0;
        #1;
        check_val("mdBusy in reset", longint'(bus.mdBusy), 0);
        check_flags("flags in reset", cur_flags(), E_IDLE);
        check_val("stallCycles in reset", longint'(bus.stallCycles), 0);
        check_val("sat stallCycles in reset", longint'(bus_s.stallCycles), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(tail[i], $sformatf("post-reset md%0d", i));
            @(posedge clk);
            #1;
        end

        check_val("scoreboard drained", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
